// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch (read-only)
// and data memory (read/write). DM has fixed priority, IF has a starvation override, and every access has an ack timeout.
module unified_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_err,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic [3:0]        dm_wstrb,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              dm_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_dm
);

   typedef enum logic [1:0] {IDLE, GNT_DM, GNT_IF} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

   state_t     state;
   logic [3:0] starve_cnt;
   logic [7:0] tmo_cnt;
   logic       if_elig, dm_elig, pick_if, pick_dm, done;

   // A requester in its valid cycle still holds req high; mask it so it is not re-granted.
   assign if_elig  = if_req & ~if_valid;
   assign dm_elig  = dm_req & ~dm_valid;
   assign pick_if  = if_elig & (~dm_elig | (starve_cnt == STARVE_LIM));
   assign pick_dm  = dm_elig & ~pick_if;
   assign done     = mem_ack | (tmo_cnt == TMO_LAST);
   assign stall_if = if_req & ~if_valid;
   assign stall_dm = dm_req & ~dm_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         if_rdata   <= '0;
         if_valid   <= 1'b0;
         if_err     <= 1'b0;
         dm_rdata   <= '0;
         dm_valid   <= 1'b0;
         dm_err     <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         if_err   <= 1'b0;
         dm_valid <= 1'b0;
         dm_err   <= 1'b0;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (pick_if) begin
                  state      <= GNT_IF;
                  starve_cnt <= '0;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  mem_wstrb  <= '0;
               end else if (pick_dm) begin
                  state     <= GNT_DM;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_wstrb <= dm_wstrb;
                  if (if_elig) starve_cnt <= starve_cnt + 4'd1;
               end
            end
            GNT_IF, GNT_DM: begin
               if (done) begin
                  // Ack takes precedence over a timeout landing on the same cycle.
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  if (state == GNT_IF) begin
                     if_valid <= 1'b1;
                     if_err   <= ~mem_ack;
                     if_rdata <= mem_ack ? mem_rdata : '0;
                  end else begin
                     dm_valid <= 1'b1;
                     dm_err   <= ~mem_ack;
                     dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, hand sequences for reset/timeout/alternation,
// then randomized protocol-following traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;

   localparam int STARVE = 4;
   localparam int TMO    = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [3:0]  dm_wstrb;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_valid, if_err, dm_valid, dm_err, mem_req, mem_we, stall_if, stall_dm;
   logic [3:0]  mem_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_dm(stall_dm)
   );

   typedef struct {
      logic ifr; logic [31:0] ia; logic dmr; logic we; logic [31:0] da; logic [31:0] wd;
      logic [3:0] ws; logic ack; logic [31:0] rd;
      logic e_req; logic e_we; logic [31:0] e_addr; logic [3:0] e_ws;
      logic e_ifv; logic e_dmv; logic [31:0] e_rd;
   } vec_t;

   vec_t tbl [13];

   // Reference model state: who owns the memory, how long it has waited, starvation count.
   int          owner, waited, starve;
   logic        m_req, m_we, m_ifv, m_dmv, m_ife, m_dme;
   logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
   logic [3:0]  m_ws;
   bit          if_busy, dm_busy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
      dm_wdata = 0; dm_wstrb = 0; mem_ack = 0; mem_rdata = 0;
   endtask

   task automatic model_finish(input bit err);
      m_req = 0;
      if (owner == 1) begin
         m_ifv = 1; m_ife = err; m_ifr = err ? 32'h0 : mem_rdata;
      end else begin
         m_dmv = 1; m_dme = err; m_dmr = (err || m_we) ? 32'h0 : mem_rdata;
      end
      owner = 0;
   endtask

   task automatic model_step();
      bit ife, dme;
      int pick;
      ife = if_req && !m_ifv;
      dme = dm_req && !m_dmv;
      m_ifv = 0; m_dmv = 0; m_ife = 0; m_dme = 0;
      if (owner == 0) begin
         waited = 0;
         if (ife && dme)  pick = (starve == STARVE) ? 1 : 2;
         else if (ife)    pick = 1;
         else if (dme)    pick = 2;
         else             pick = 0;
         if (pick == 1) begin
            starve = 0; m_req = 1; m_we = 0; m_addr = if_addr; m_ws = 0;
         end else if (pick == 2) begin
            if (ife) starve++;
            m_req = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_ws = dm_wstrb;
         end
         owner = pick;
      end else if (mem_ack) begin
         model_finish(0);
      end else begin
         waited++;
         if (waited == TMO) model_finish(1);
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1,32'h100,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,        1'b1,1'b0,32'h100,4'h0,1'b0,1'b0,32'h0};
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = '{1'b1,32'h100,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,32'h00500093, 1'b0,1'b0,32'h0,4'h0,1'b1,1'b0,32'h00500093};
      tbl[4]  = '{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,          1'b0,1'b0,32'h0,4'h0,1'b0,1'b0,32'h0};
      tbl[5]  = '{1'b1,32'h104,1'b1,1'b1,32'h200,32'hDEADBEEF,4'hF,1'b0,32'h0, 1'b1,1'b1,32'h200,4'hF,1'b0,1'b0,32'h0};
      tbl[6]  = '{1'b1,32'h104,1'b1,1'b1,32'h200,32'hDEADBEEF,4'hF,1'b1,32'h12345678, 1'b0,1'b0,32'h0,4'h0,1'b0,1'b1,32'h0};
      tbl[7]  = '{1'b1,32'h104,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,        1'b1,1'b0,32'h104,4'h0,1'b0,1'b0,32'h0};
      tbl[8]  = '{1'b1,32'h104,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,32'hCAFEF00D, 1'b0,1'b0,32'h0,4'h0,1'b1,1'b0,32'hCAFEF00D};
      tbl[9]  = tbl[4];
      tbl[10] = '{1'b0,32'h0,1'b1,1'b0,32'h300,32'h0,4'h0,1'b0,32'h0,        1'b1,1'b0,32'h300,4'h0,1'b0,1'b0,32'h0};
      tbl[11] = '{1'b0,32'h0,1'b1,1'b0,32'h300,32'h0,4'h0,1'b1,32'hA5A5A5A5, 1'b0,1'b0,32'h0,4'h0,1'b0,1'b1,32'hA5A5A5A5};
      tbl[12] = tbl[4];

      // Reset held with a pending IF request, then released.
      idle_inputs();
      reset = 0; if_req = 1; if_addr = 32'h80;
      repeat (3) tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_dm_valid", dm_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_errs", {if_err, dm_err}, 0);
      reset = 1;
      tick();
      chk("rel_mem_req", mem_req, 1);
      chk("rel_mem_addr", mem_addr, 32'h80);
      mem_ack = 1; mem_rdata = 32'h13;
      tick();
      chk("rel_if_valid", if_valid, 1);
      chk("rel_if_rdata", if_rdata, 32'h13);
      chk("rel_mem_req_off", mem_req, 0);
      if_req = 0; mem_ack = 0;
      tick();
      chk("rel_if_valid_pulse", if_valid, 0);

      // Table: IF read with late ack, collision with DM write, DM read.
      for (int i = 0; i < 13; i++) begin
         if_req = tbl[i].ifr; if_addr = tbl[i].ia; dm_req = tbl[i].dmr; dm_we = tbl[i].we;
         dm_addr = tbl[i].da; dm_wdata = tbl[i].wd; dm_wstrb = tbl[i].ws;
         mem_ack = tbl[i].ack; mem_rdata = tbl[i].rd;
         tick();
         chk($sformatf("vec%0d_mem_req", i), mem_req, tbl[i].e_req);
         chk($sformatf("vec%0d_if_valid", i), if_valid, tbl[i].e_ifv);
         chk($sformatf("vec%0d_dm_valid", i), dm_valid, tbl[i].e_dmv);
         chk($sformatf("vec%0d_stall_if", i), stall_if, tbl[i].ifr & ~tbl[i].e_ifv);
         chk($sformatf("vec%0d_stall_dm", i), stall_dm, tbl[i].dmr & ~tbl[i].e_dmv);
         if (tbl[i].e_req) begin
            chk($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].e_we);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_mem_wstrb", i), mem_wstrb, tbl[i].e_ws);
            if (tbl[i].e_we) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, tbl[i].wd);
         end
         if (tbl[i].e_ifv) chk($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].e_rd);
         if (tbl[i].e_dmv) chk($sformatf("vec%0d_dm_rdata", i), dm_rdata, tbl[i].e_rd);
      end

      // DM read that never gets an ack: abort after TMO grant cycles, late ack ignored.
      idle_inputs();
      dm_req = 1; dm_addr = 32'h400;
      tick();
      chk("tmo_gnt", mem_req, 1);
      for (int k = 0; k < TMO - 1; k++) begin
         tick();
         chk("tmo_hold", {mem_req, dm_valid}, 2'b10);
      end
      tick();
      chk("tmo_mem_req", mem_req, 0);
      chk("tmo_valid_err", {dm_valid, dm_err}, 2'b11);
      chk("tmo_rdata", dm_rdata, 0);
      chk("tmo_if_quiet", {if_valid, if_err}, 0);
      dm_req = 0; mem_ack = 1; mem_rdata = 32'hFFFF0000;
      tick();
      chk("late_ack_valid", {dm_valid, dm_err}, 0);
      chk("late_ack_mem_req", mem_req, 0);
      mem_ack = 0;

      // Simultaneous requests: DM first, IF taken in the DM valid cycle, then DM again.
      if_req = 1; if_addr = 32'h500; dm_req = 1; dm_we = 0; dm_addr = 32'h600;
      tick();
      chk("alt_dm_first", mem_addr, 32'h600);
      mem_ack = 1; mem_rdata = 32'h66;
      tick();
      chk("alt_dm_valid", dm_valid, 1);
      mem_ack = 0;
      tick();
      chk("alt_if_next", {mem_req, mem_we}, 2'b10);
      chk("alt_if_addr", mem_addr, 32'h500);
      mem_ack = 1; mem_rdata = 32'h55;
      tick();
      chk("alt_if_valid", if_valid, 1);
      chk("alt_if_rdata", if_rdata, 32'h55);
      if_req = 0; mem_ack = 0;
      tick();
      chk("alt_dm_again", mem_addr, 32'h600);
      mem_ack = 1;
      tick();
      chk("alt_dm_valid2", dm_valid, 1);
      idle_inputs();
      tick();

      // Reset in the middle of an IF grant.
      if_req = 1; if_addr = 32'h700;
      tick();
      chk("mid_gnt", mem_req, 1);
      #2 reset = 0;
      #1 chk("mid_async_drop", mem_req, 0);
      tick();
      reset = 1; if_req = 0; mem_ack = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mid_no_valid", {if_valid, mem_req}, 0);
      end
      mem_ack = 0; if_req = 1; if_addr = 32'h704;
      tick();
      chk("mid_rereq_addr", mem_addr, 32'h704);
      mem_ack = 1; mem_rdata = 32'h11;
      tick();
      chk("mid_rereq_valid", if_valid, 1);
      chk("mid_rereq_rdata", if_rdata, 32'h11);
      idle_inputs();

      // Randomized traffic against the reference model.
      reset = 0;
      tick();
      reset = 1;
      owner = 0; waited = 0; starve = 0;
      m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_ws = 0;
      m_ifv = 0; m_dmv = 0; m_ife = 0; m_dme = 0; m_ifr = 0; m_dmr = 0;
      if_busy = 0; dm_busy = 0;
      for (int c = 0; c < 3000; c++) begin
         if (m_ifv) if_busy = 0;
         if (m_dmv) dm_busy = 0;
         if (!if_busy) begin
            if ($urandom_range(0, 2) == 0) begin
               if_busy = 1; if_req = 1; if_addr = $urandom & 32'hFFFFFFFC;
            end else if_req = 0;
         end
         if (!dm_busy) begin
            if ($urandom_range(0, 2) == 0) begin
               dm_busy = 1; dm_req = 1; dm_we = 1'($urandom_range(0, 1));
               dm_addr = $urandom; dm_wdata = $urandom; dm_wstrb = 4'($urandom_range(0, 15));
            end else dm_req = 0;
         end
         mem_rdata = $urandom;
         mem_ack = m_req ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0);
         #1;
         chk("rnd_stall_if", stall_if, if_req & ~m_ifv);
         chk("rnd_stall_dm", stall_dm, dm_req & ~m_dmv);
         model_step();
         @(posedge clk);
         #1;
         chk("rnd_mem_req", mem_req, m_req);
         chk("rnd_valids", {if_valid, dm_valid}, {m_ifv, m_dmv});
         chk("rnd_errs", {if_err, dm_err}, {m_ife, m_dme});
         chk("rnd_if_rdata", if_rdata, m_ifr);
         chk("rnd_dm_rdata", dm_rdata, m_dmr);
         if (m_req) begin
            chk("rnd_mem_we", mem_we, m_we);
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_wstrb", mem_wstrb, m_ws);
            if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
